sdram_frame_sched: RTL and testbench
====================================

// Module: sdram_frame_sched
// PURPOSE
//  Schedules single-row burst requests from the capture write FIFO and the VGA read FIFO onto the one req/ack port pair of sdram_top.
//  Manages a two-bank ping-pong frame store: writer fills one bank, reader scans the last completed bank per VGA frame.
//  Owns all SDRAM addressing, frame-valid status and an ack watchdog. Runs entirely in the clk_133M domain.
// PARAMETERS
//  BURST_LEN      512   words per row burst; write issued only when wr FIFO holds >= BURST_LEN
//  ROWS_PER_FRAME 128   row bursts per frame (1..8191)
//  RD_URGENT_WM   256   rd_fifo_used <= this -> read wins arbitration unconditionally
//  RD_REQ_WM      512   rd_fifo_used <= this -> read eligible
//  ACK_TIMEOUT    4095  cycles a req may wait for ack before abort
// PORTS
//  clk_133M       in   1   system SDRAM clock
//  rst_133        in   1   reset: rst_133, asynchronous, active-low; clock clk_133M
//  frame_start    in   1   1-cycle pulse, VSYNC falling edge already synced to clk_133M
//  wr_fifo_used   in   11  capture FIFO fill level
//  rd_fifo_used   in   11  VGA FIFO fill level
//  wr_sdram_req   out  1   write burst request to sdram_top
//  wr_sdram_ack   in   1   1-cycle pulse: write burst done
//  wr_sdram_add   out  24  {bank[1:0], row[12:0], col[8:0]}; col always 0
//  rd_sdram_req   out  1   read burst request to sdram_top
//  rd_sdram_ack   in   1   1-cycle pulse: read burst done
//  rd_sdram_add   out  24  same format as wr_sdram_add
//  frame_valid    out  1   sticky: at least one full frame stored; gates VGA FIFO reads
//  rd_bank_o      out  1   bank currently scanned by reader
//  ack_err        out  1   sticky: watchdog fired
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; wr_row=rd_row=0; wr_bank=0; last_bank=0; rd_done=1.
//  FSM IDLE -> GRANT_WR | GRANT_RD -> IDLE. At most one req high at any time.
//   IDLE evaluates (priority order): rd_elig & rd_fifo_used<=RD_URGENT_WM -> RD;
//    wr_elig -> WR; rd_elig -> RD. rd_elig = frame_valid & !rd_done & rd_fifo_used<=RD_REQ_WM.
//    wr_elig = wr_fifo_used>=BURST_LEN.
//   Req asserts the cycle after the IDLE decision, held high until ack; req drops the cycle after ack; FSM returns to IDLE (>=1 idle cycle between grants).
//   Addresses stable for the whole req window; update only on ack.
//  Write path: on wr ack wr_row++. If wr_row reaches ROWS_PER_FRAME: wr_row<=0, last_bank<=wr_bank, wr_bank<=~wr_bank, frame_valid<=1.
//  Read path: on rd ack rd_row++; rd_row==ROWS_PER_FRAME -> rd_done<=1 (no further reads this frame).
//  frame_start: rd_row<=0, rd_bank<=last_bank, rd_done<=!frame_valid. If a read is in flight, the reload is deferred and applied on its ack (ack's increment discarded).
//  frame_start with no prior full frame: reader stays idle, frame_valid 0.
//  Write completing same cycle as frame_start: frame_start samples updated last_bank (new frame wins).
//  Bank field: bit 22 = bank select, bit 23 = 0. Writer does not avoid rd_bank; tearing on writer overrun is accepted.
//  Watchdog: 12-bit counter runs while any req high, clears on ack/IDLE; on reaching ACK_TIMEOUT drop req, set ack_err, return IDLE, no address advance.
//  Ack arriving while FSM not in the matching grant state is ignored.
//  Async reset mid-burst: req drops immediately; sdram_top is reset by the same rst_133.
// TESTING
//  1) wr_fifo_used=512, rd=0 -> wr_sdram_req, ack after 20 cyc -> req low next cycle, wr_sdram_add=24'h000200.
//  2) 128 write acks -> frame_valid=1, last_bank=0, next wr_sdram_add=24'h400000; frame_start -> rd_sdram_add=24'h000000.
//  3) Both eligible, rd_fifo_used=300 -> write granted first; rd_fifo_used=100 -> read granted first.
//  4) frame_start during read req at row 5 -> on ack rd_sdram_add row=0, bank=last_bank.
//  5) Read 128 rows -> rd_done=1, no rd_sdram_req until next frame_start.
//  6) No ack for 4095 cycles -> req low, ack_err=1, address unchanged; assert rst_133 low mid-req -> all outputs 0.

Source files
------------

// File: rtl/sdram_frame_sched.sv
// rtl/sdram_frame_sched.sv - ping-pong frame store scheduler for the sdram_top req/ack port
// Purpose: arbitrates single-row burst requests between the capture write FIFO and
//   the VGA read FIFO onto one req/ack pair, owns all SDRAM addressing, the
//   frame-valid status and an ack watchdog. Single clock domain (clk_133M).
// Ports:
//   clk_133M, rst_133           clock, asynchronous active-low reset
//   frame_start                 1-cycle VGA frame pulse (already synced)
//   wr_fifo_used, rd_fifo_used  capture / VGA FIFO fill levels
//   wr_sdram_req/ack/add        write burst handshake, {bank[1:0],row[12:0],col[8:0]}
//   rd_sdram_req/ack/add        read burst handshake, same address format
//   frame_valid                 sticky: a full frame has been stored
//   rd_bank_o                   bank currently scanned by the reader
//   ack_err                     sticky: watchdog aborted a request
module sdram_frame_sched #(
  parameter int unsigned BURST_LEN      = 512,
  parameter int unsigned ROWS_PER_FRAME = 128,
  parameter int unsigned RD_URGENT_WM   = 256,
  parameter int unsigned RD_REQ_WM      = 512,
  parameter int unsigned ACK_TIMEOUT    = 4095
) (
  input  logic        clk_133M,
  input  logic        rst_133,
  input  logic        frame_start,
  input  logic [10:0] wr_fifo_used,
  input  logic [10:0] rd_fifo_used,
  output logic        wr_sdram_req,
  input  logic        wr_sdram_ack,
  output logic [23:0] wr_sdram_add,
  output logic        rd_sdram_req,
  input  logic        rd_sdram_ack,
  output logic [23:0] rd_sdram_add,
  output logic        frame_valid,
  output logic        rd_bank_o,
  output logic        ack_err
);

  localparam logic [10:0] BURST_W  = 11'(BURST_LEN);
  localparam logic [10:0] URGENT_W = 11'(RD_URGENT_WM);
  localparam logic [10:0] REQ_W    = 11'(RD_REQ_WM);
  localparam logic [13:0] ROWS_W   = 14'(ROWS_PER_FRAME);
  localparam logic [11:0] WD_LAST  = 12'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GRANT_WR, GRANT_RD} state_t;

  state_t      state_q;
  logic        wr_req_q, rd_req_q;
  logic [12:0] wr_row_q, rd_row_q;
  logic        wr_bank_q, last_bank_q, rd_bank_q;
  logic        rd_done_q, frame_valid_q, ack_err_q;
  logic        reload_pend_q;
  logic [11:0] wd_q;

  logic wr_ack_hit, rd_ack_hit, wd_expire, rd_in_flight;
  logic wr_row_wrap, rd_row_end, frame_done;
  logic last_bank_d, frame_valid_d;
  logic rd_elig, rd_urgent, wr_elig, reload_now;

  // Acks only count while the matching grant is outstanding.
  assign wr_ack_hit   = (state_q == GRANT_WR) && wr_sdram_ack;
  assign rd_ack_hit   = (state_q == GRANT_RD) && rd_sdram_ack;
  assign rd_in_flight = (state_q == GRANT_RD);
  // wd_q counts completed waiting cycles; the last allowed one triggers the abort.
  assign wd_expire    = (state_q != IDLE) && (wd_q == WD_LAST);

  assign wr_row_wrap  = ({1'b0, wr_row_q} + 14'd1) == ROWS_W;
  assign rd_row_end   = ({1'b0, rd_row_q} + 14'd1) == ROWS_W;
  assign frame_done   = wr_ack_hit && wr_row_wrap;

  // A frame completing in the same cycle as frame_start is visible to the reload.
  assign last_bank_d   = frame_done ? wr_bank_q : last_bank_q;
  assign frame_valid_d = frame_valid_q | frame_done;

  assign rd_elig   = frame_valid_q && !rd_done_q && (rd_fifo_used <= REQ_W);
  assign rd_urgent = rd_elig && (rd_fifo_used <= URGENT_W);
  assign wr_elig   = wr_fifo_used >= BURST_W;

  // A read in flight keeps its address; the reload waits for its ack (or abort).
  assign reload_now = (frame_start || reload_pend_q) &&
                      (!rd_in_flight || rd_ack_hit || wd_expire);

  always_ff @(posedge clk_133M or negedge rst_133) begin
    if (!rst_133) begin
      state_q       <= IDLE;
      wr_req_q      <= 1'b0;
      rd_req_q      <= 1'b0;
      wr_row_q      <= '0;
      rd_row_q      <= '0;
      wr_bank_q     <= 1'b0;
      last_bank_q   <= 1'b0;
      rd_bank_q     <= 1'b0;
      rd_done_q     <= 1'b1;
      frame_valid_q <= 1'b0;
      ack_err_q     <= 1'b0;
      reload_pend_q <= 1'b0;
      wd_q          <= '0;
    end else begin
      frame_valid_q <= frame_valid_d;
      last_bank_q   <= last_bank_d;

      case (state_q)
        IDLE: begin
          wd_q <= '0;
          if (rd_urgent) begin
            state_q  <= GRANT_RD;
            rd_req_q <= 1'b1;
          end else if (wr_elig) begin
            state_q  <= GRANT_WR;
            wr_req_q <= 1'b1;
          end else if (rd_elig) begin
            state_q  <= GRANT_RD;
            rd_req_q <= 1'b1;
          end
        end
        GRANT_WR: begin
          if (wr_sdram_ack || wd_expire) begin
            state_q  <= IDLE;
            wr_req_q <= 1'b0;
            wd_q     <= '0;
            if (!wr_sdram_ack) ack_err_q <= 1'b1;
          end else begin
            wd_q <= wd_q + 12'd1;
          end
        end
        GRANT_RD: begin
          if (rd_sdram_ack || wd_expire) begin
            state_q  <= IDLE;
            rd_req_q <= 1'b0;
            wd_q     <= '0;
            if (!rd_sdram_ack) ack_err_q <= 1'b1;
          end else begin
            wd_q <= wd_q + 12'd1;
          end
        end
        default: begin
          state_q  <= IDLE;
          wr_req_q <= 1'b0;
          rd_req_q <= 1'b0;
          wd_q     <= '0;
        end
      endcase

      if (wr_ack_hit) begin
        if (wr_row_wrap) begin
          wr_row_q  <= '0;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          wr_row_q <= wr_row_q + 13'd1;
        end
      end

      reload_pend_q <= rd_in_flight && !rd_ack_hit && !wd_expire &&
                       (frame_start || reload_pend_q);

      // A deferred reload replaces the ack's row increment.
      if (reload_now) begin
        rd_row_q  <= '0;
        rd_bank_q <= last_bank_d;
        rd_done_q <= !frame_valid_d;
      end else if (rd_ack_hit) begin
        rd_row_q <= rd_row_q + 13'd1;
        if (rd_row_end) rd_done_q <= 1'b1;
      end
    end
  end

  assign wr_sdram_req = wr_req_q;
  assign rd_sdram_req = rd_req_q;
  assign wr_sdram_add = {1'b0, wr_bank_q, wr_row_q, 9'd0};
  assign rd_sdram_add = {1'b0, rd_bank_q, rd_row_q, 9'd0};
  assign frame_valid  = frame_valid_q;
  assign rd_bank_o    = rd_bank_q;
  assign ack_err      = ack_err_q;

endmodule

// File: tb/tb_sdram_frame_sched.sv
// tb/tb_sdram_frame_sched.sv - self-checking bench for sdram_frame_sched
module tb_sdram_frame_sched;

  localparam int BURST_LEN   = 512;
  localparam int ROWS        = 128;
  localparam int URGENT_WM   = 256;
  localparam int REQ_WM      = 512;
  localparam int ACK_TIMEOUT = 4095;

  logic        clk_133M = 1'b0;
  logic        rst_133 = 1'b0;
  logic        frame_start = 1'b0;
  logic [10:0] wr_fifo_used = '0;
  logic [10:0] rd_fifo_used = '0;
  logic        wr_sdram_ack = 1'b0;
  logic        rd_sdram_ack = 1'b0;
  logic        wr_sdram_req, rd_sdram_req;
  logic [23:0] wr_sdram_add, rd_sdram_add;
  logic        frame_valid, rd_bank_o, ack_err;

  int n_checks = 0;
  int n_fail = 0;

  sdram_frame_sched dut (
    .clk_133M     (clk_133M),
    .rst_133      (rst_133),
    .frame_start  (frame_start),
    .wr_fifo_used (wr_fifo_used),
    .rd_fifo_used (rd_fifo_used),
    .wr_sdram_req (wr_sdram_req),
    .wr_sdram_ack (wr_sdram_ack),
    .wr_sdram_add (wr_sdram_add),
    .rd_sdram_req (rd_sdram_req),
    .rd_sdram_ack (rd_sdram_ack),
    .rd_sdram_add (rd_sdram_add),
    .frame_valid  (frame_valid),
    .rd_bank_o    (rd_bank_o),
    .ack_err      (ack_err)
  );

  always #5 clk_133M = ~clk_133M;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bus owner (0 none, 1 writer, 2 reader), bursts written since reset,
  // rows read in the current scan, and the reader's bank/scan status.
  int m_owner = 0;
  int m_wait = 0;
  int m_wr_done = 0;
  int m_rd_rows = 0;
  bit m_rd_bank = 1'b0;
  bit m_scan = 1'b0;
  bit m_pend = 1'b0;
  bit m_err = 1'b0;

  function automatic logic [23:0] mk_add(input bit bank, input int row);
    logic [12:0] r;
    r = row[12:0];
    return {1'b0, bank, r, 9'd0};
  endfunction

  always @(posedge clk_133M or negedge rst_133) begin
    if (!rst_133) begin
      m_owner = 0; m_wait = 0; m_wr_done = 0; m_rd_rows = 0;
      m_rd_bank = 1'b0; m_scan = 1'b0; m_pend = 1'b0; m_err = 1'b0;
    end else begin
      bit fv_before, fv_after, wr_hit, rd_hit, expire, reading, lb, rd_ok, rd_urg;
      fv_before = (m_wr_done >= ROWS);
      wr_hit    = (m_owner == 1) && wr_sdram_ack;
      rd_hit    = (m_owner == 2) && rd_sdram_ack;
      expire    = (m_owner != 0) && !wr_hit && !rd_hit && (m_wait + 1 == ACK_TIMEOUT);
      reading   = (m_owner == 2);
      if (m_owner == 0) begin
        rd_ok  = fv_before && m_scan && (int'(rd_fifo_used) <= REQ_WM);
        rd_urg = rd_ok && (int'(rd_fifo_used) <= URGENT_WM);
        m_wait = 0;
        if (rd_urg) m_owner = 2;
        else if (int'(wr_fifo_used) >= BURST_LEN) m_owner = 1;
        else if (rd_ok) m_owner = 2;
      end else if (wr_hit || rd_hit || expire) begin
        m_owner = 0;
        m_wait = 0;
        if (expire) m_err = 1'b1;
      end else begin
        m_wait++;
      end
      if (wr_hit) m_wr_done++;
      fv_after = (m_wr_done >= ROWS);
      lb = fv_after ? ((((m_wr_done / ROWS) - 1) % 2) == 1) : 1'b0;
      if (reading && !rd_hit && !expire) begin
        if (frame_start) m_pend = 1'b1;
      end else if (frame_start || m_pend) begin
        m_rd_rows = 0; m_rd_bank = lb; m_scan = fv_after; m_pend = 1'b0;
      end else if (rd_hit) begin
        m_rd_rows++;
        if (m_rd_rows == ROWS) m_scan = 1'b0;
      end
    end
  end

  always @(negedge clk_133M) begin
    chk("wr_req", 24'(wr_sdram_req), 24'(m_owner == 1));
    chk("rd_req", 24'(rd_sdram_req), 24'(m_owner == 2));
    chk("wr_add", wr_sdram_add, mk_add(((m_wr_done / ROWS) % 2) == 1, m_wr_done % ROWS));
    chk("rd_add", rd_sdram_add, mk_add(m_rd_bank, m_rd_rows));
    chk("frame_valid", 24'(frame_valid), 24'(m_wr_done >= ROWS));
    chk("rd_bank", 24'(rd_bank_o), 24'(m_rd_bank));
    chk("ack_err", 24'(ack_err), 24'(m_err));
  end

  task automatic tick();
    @(posedge clk_133M);
    #2;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_req(input bit is_wr);
    int n;
    n = 0;
    while (((is_wr ? wr_sdram_req : rd_sdram_req) == 1'b0) && n < 50) begin
      tick();
      n++;
    end
    chk("req_seen", 24'(is_wr ? wr_sdram_req : rd_sdram_req), 24'd1);
  endtask

  task automatic give_ack(input bit is_wr);
    if (is_wr) wr_sdram_ack = 1'b1; else rd_sdram_ack = 1'b1;
    tick();
    wr_sdram_ack = 1'b0;
    rd_sdram_ack = 1'b0;
  endtask

  task automatic serve(input bit is_wr, input int delay);
    wait_req(is_wr);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("req_held", 24'(is_wr ? wr_sdram_req : rd_sdram_req), 24'd1);
    end
    give_ack(is_wr);
  endtask

  initial begin
    int n;
    tick();
    tick();
    chk("rst_wr_req", 24'(wr_sdram_req), 24'd0);
    chk("rst_wr_add", wr_sdram_add, 24'h000000);
    chk("rst_frame_valid", 24'(frame_valid), 24'd0);
    rst_133 = 1'b1;
    tick();

    // 1) single write burst, ack after 20 cycles
    wr_fifo_used = 11'd512;
    rd_fifo_used = 11'd0;
    serve(1'b1, 20);
    chk("t1_req_low", 24'(wr_sdram_req), 24'd0);
    chk("t1_wr_add", wr_sdram_add, 24'h000200);

    // 2) complete the first frame
    for (int i = 1; i < ROWS; i++) serve(1'b1, 2);
    wr_fifo_used = 11'd0;
    rd_fifo_used = 11'd600;
    chk("t2_frame_valid", 24'(frame_valid), 24'd1);
    chk("t2_wr_add", wr_sdram_add, 24'h400000);
    pulse_frame();
    tick();
    chk("t2_rd_add", rd_sdram_add, 24'h000000);
    chk("t2_rd_bank", 24'(rd_bank_o), 24'd0);

    // 3) arbitration: non-urgent read loses, urgent read wins
    wr_fifo_used = 11'd512;
    rd_fifo_used = 11'd300;
    tick();
    chk("t3_wr_first", 24'(wr_sdram_req), 24'd1);
    chk("t3_rd_waits", 24'(rd_sdram_req), 24'd0);
    serve(1'b1, 2);
    chk("t3_wr_add", wr_sdram_add, 24'h400200);
    rd_fifo_used = 11'd100;
    tick();
    chk("t3_rd_first", 24'(rd_sdram_req), 24'd1);
    chk("t3_wr_waits", 24'(wr_sdram_req), 24'd0);
    serve(1'b0, 3);
    chk("t3_rd_add", rd_sdram_add, 24'h000200);

    // finish the second frame so last_bank becomes 1
    rd_fifo_used = 11'd600;
    while (m_wr_done < 2 * ROWS) serve(1'b1, 1);
    wr_fifo_used = 11'd0;
    chk("t3_last_wr_add", wr_sdram_add, 24'h000000);

    // 4) frame_start while read of row 5 is in flight
    rd_fifo_used = 11'd100;
    for (int i = 0; i < 4; i++) serve(1'b0, 1);
    wait_req(1'b0);
    chk("t4_row5", rd_sdram_add, 24'h000A00);
    pulse_frame();
    tick();
    chk("t4_add_stable", rd_sdram_add, 24'h000A00);
    give_ack(1'b0);
    chk("t4_reload_add", rd_sdram_add, 24'h400000);
    chk("t4_reload_bank", 24'(rd_bank_o), 24'd1);

    // 5) scan a whole frame, then the reader stays quiet
    for (int i = 0; i < ROWS; i++) serve(1'b0, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t5_rd_quiet", 24'(rd_sdram_req), 24'd0);
    end
    wr_sdram_ack = 1'b1;
    rd_sdram_ack = 1'b1;
    tick();
    wr_sdram_ack = 1'b0;
    rd_sdram_ack = 1'b0;
    tick();
    chk("t5_stray_wr_add", wr_sdram_add, 24'h000000);
    chk("t5_stray_rd_add", rd_sdram_add, 24'h410000);

    // 6) next frame's first read is never acked
    pulse_frame();
    tick();
    chk("t6_req_up", 24'(rd_sdram_req), 24'd1);
    chk("t6_rd_add", rd_sdram_add, 24'h400000);
    n = 0;
    while (rd_sdram_req && n < 5000) begin
      n++;
      tick();
    end
    chk("t6_req_cycles", 24'(n), 24'(ACK_TIMEOUT));
    chk("t6_ack_err", 24'(ack_err), 24'd1);
    chk("t6_add_kept", rd_sdram_add, 24'h400000);
    tick();
    chk("t6_retry", 24'(rd_sdram_req), 24'd1);
    tick();
    rst_133 = 1'b0;
    #1;
    chk("t6_rst_rd_req", 24'(rd_sdram_req), 24'd0);
    chk("t6_rst_wr_req", 24'(wr_sdram_req), 24'd0);
    chk("t6_rst_rd_add", rd_sdram_add, 24'h000000);
    chk("t6_rst_wr_add", wr_sdram_add, 24'h000000);
    chk("t6_rst_fv", 24'(frame_valid), 24'd0);
    chk("t6_rst_bank", 24'(rd_bank_o), 24'd0);
    chk("t6_rst_err", 24'(ack_err), 24'd0);
    tick();
    tick();
    rst_133 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t6_post_rst_req", 24'(rd_sdram_req), 24'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_checks++;
    n_fail++;
    $display("FAIL global_timeout: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
